// File: rtl/store_buffer_pkg.sv
// Shared defaults for the store buffer slice. STORE_BUFFER_FWD_EN is left
// undefined by default, so the buffer drains ahead of every load.
`timescale 1ns/1ps
package store_buffer_pkg;
   localparam int SB_DEPTH    = 4;
   localparam int SB_AW       = 32;
   localparam int SB_DW       = 32;
   localparam int SB_WORD_LSB = 2;
endpackage

// File: rtl/store_buffer_if.sv
// Core data port plus memory read/write port of the store buffer.
// slave is the buffer side, master is the core/memory environment side.
`timescale 1ns/1ps
interface store_buffer_if
   import store_buffer_pkg::*;
#(
   parameter int AW = SB_AW,
   parameter int DW = SB_DW
);
   logic          memwrite;
   logic          memread;
   logic [AW-1:0] memaddr;
   logic [DW-1:0] memwritedata;
   logic [DW-1:0] memreaddata;
   logic          stall;
   logic [AW-1:0] mem_raddr;
   logic [DW-1:0] mem_rdata;
   logic          mem_wvalid;
   logic          mem_wready;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
   logic          sb_empty;

   modport slave (
      input  memwrite, memread, memaddr, memwritedata, mem_rdata, mem_wready,
      output memreaddata, stall, mem_raddr, mem_wvalid, mem_waddr, mem_wdata, sb_empty
   );

   modport master (
      output memwrite, memread, memaddr, memwritedata, mem_rdata, mem_wready,
      input  memreaddata, stall, mem_raddr, mem_wvalid, mem_waddr, mem_wdata, sb_empty
   );
endinterface

// File: rtl/store_buffer_fifo.sv
// sb_entry_fifo: circular store-entry storage with head/tail/count.
// With STORE_BUFFER_FWD_EN it also exposes every slot for load forwarding.
`timescale 1ns/1ps
module sb_entry_fifo
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int W     = SB_AW + SB_DW,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head_data,
   output logic         full,
   output logic         empty
`ifdef STORE_BUFFER_FWD_EN
   ,
   output logic [PW-1:0]            head_ptr,
   output logic [CW-1:0]            count_o,
   output logic [DEPTH-1:0][W-1:0]  entries
`endif
);
   logic [W-1:0]  store [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

   // Payload is not reset; count alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (push) store[tail] <= push_data;
   end

   assign head_data = store[head];
   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);

`ifdef STORE_BUFFER_FWD_EN
   assign head_ptr = head;
   assign count_o  = count;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) entries[i] = store[i];
   end
`endif
endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and data memory.
// Define STORE_BUFFER_FWD_EN for youngest-match load forwarding; otherwise loads wait for drain.
`timescale 1ns/1ps
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW
) (
   input  logic          clk,
   input  logic          reset,
   store_buffer_if.slave bus
);
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic          stall;
   logic          wvalid;
   logic [AW+DW-1:0] head_data;
   logic [AW-1:0] head_addr;
   logic [DW-1:0] head_wdata;

   // Full-buffer stall ignores mem_wready so there is no ready-to-stall path.
`ifdef STORE_BUFFER_FWD_EN
   assign stall = bus.memwrite & full;
`else
   assign stall = (bus.memwrite & full) | (bus.memread & ~empty);
`endif

   assign push   = bus.memwrite & ~stall;
   assign wvalid = ~empty;
   assign pop    = wvalid & bus.mem_wready;

   assign {head_addr, head_wdata} = head_data;

`ifdef STORE_BUFFER_FWD_EN
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [PW-1:0]               head_ptr;
   logic [CW-1:0]               count;
   logic [DEPTH-1:0][AW+DW-1:0] entries;
   logic [PW-1:0]               idx;
   logic [DW-1:0]               fwd_data;
`endif

   sb_entry_fifo #(
      .DEPTH (DEPTH),
      .W     (AW + DW)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({bus.memaddr, bus.memwritedata}),
      .pop       (pop),
      .head_data (head_data),
      .full      (full),
      .empty     (empty)
`ifdef STORE_BUFFER_FWD_EN
      ,
      .head_ptr  (head_ptr),
      .count_o   (count),
      .entries   (entries)
`endif
   );

   assign bus.stall      = stall;
   assign bus.sb_empty   = empty;
   assign bus.mem_raddr  = bus.memaddr;
   assign bus.mem_wvalid = wvalid;
   assign bus.mem_waddr  = wvalid ? head_addr  : '0;
   assign bus.mem_wdata  = wvalid ? head_wdata : '0;

`ifdef STORE_BUFFER_FWD_EN
   // Walk oldest to youngest so the youngest match wins; the draining head still counts.
   always_comb begin
      fwd_data = bus.mem_rdata;
      idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_ptr + PW'(k);
         if ((CW'(k) < count) &&
             (entries[idx][AW+DW-1:DW+SB_WORD_LSB] == bus.memaddr[AW-1:SB_WORD_LSB]))
            fwd_data = entries[idx][DW-1:0];
      end
   end

   assign bus.memreaddata = fwd_data;
`else
   assign bus.memreaddata = bus.mem_rdata;
`endif
endmodule
